// File: rtl/tex_uv_if.sv
// Handshake bundle between a span setup source and tex_uv_stepper.
// The master drives the span setup (start, tsp_inst, u/v start and
// increments, span_len) and uv_ready. The slave returns busy, the
// per-pixel coordinate stream (uv_valid, ui, vi, pix_x, span_last)
// and the span_done pulse.
interface tex_uv_if #(
  parameter int MAX_SPAN = 32
);
  localparam int LEN_W = $clog2(MAX_SPAN + 1);
  localparam int PIX_W = $clog2(MAX_SPAN);

  logic             start;
  logic [31:0]      tsp_inst;
  logic [31:0]      u_start;
  logic [31:0]      v_start;
  logic [31:0]      du_dx;
  logic [31:0]      dv_dx;
  logic [LEN_W-1:0] span_len;
  logic             busy;
  logic             uv_valid;
  logic             uv_ready;
  logic [9:0]       ui;
  logic [9:0]       vi;
  logic [PIX_W-1:0] pix_x;
  logic             span_last;
  logic             span_done;

  modport master (
    output start, tsp_inst, u_start, v_start, du_dx, dv_dx, span_len, uv_ready,
    input  busy, uv_valid, ui, vi, pix_x, span_last, span_done
  );

  modport slave (
    input  start, tsp_inst, u_start, v_start, du_dx, dv_dx, span_len, uv_ready,
    output busy, uv_valid, ui, vi, pix_x, span_last, span_done
  );
endinterface

// File: rtl/tex_uv_stepper.sv
// Per-span texture coordinate generator feeding texture_address.
// Steps signed 16.16 U/V accumulators across a span of up to MAX_SPAN
// pixels and applies the per-axis wrap mode (repeat / flip / clamp)
// from the TSP instruction word, emitting one 10-bit texel coordinate
// pair per accepted handshake.
// Ports:
//   clock    - clock
//   reset_n  - asynchronous active-low reset
//   uv       - tex_uv_if slave: span setup in, coordinate stream out,
//              busy and span_done status
module tex_uv_stepper #(
  parameter int MAX_SPAN = 32
) (
  input  logic     clock,
  input  logic     reset_n,
  tex_uv_if.slave  uv
);
  localparam int LEN_W = $clog2(MAX_SPAN + 1);
  localparam int PIX_W = $clog2(MAX_SPAN);

  typedef enum logic {IDLE, RUN} state_t;

  // Wrap one axis. i is the signed integer part of the accumulator;
  // the texture edge is S = 8 << size. Clamp wins over flip.
  function automatic logic [9:0] map_axis(
    input logic signed [15:0] i,
    input logic [2:0]         size,
    input logic               flip,
    input logic               clamp
  );
    logic signed [15:0] s;
    logic [9:0]         s_m1;
    logic [9:0]         m;
    logic [3:0]         lg;
    s    = 16'sd8 <<< size;
    s_m1 = 10'(s - 16'sd1);
    lg   = {1'b0, size} + 4'd3;
    m    = i[9:0] & s_m1;
    if (clamp) begin
      if (i < 16'sd0)
        map_axis = '0;
      else if (i >= s)
        map_axis = s_m1;
      else
        map_axis = i[9:0];
    end else if (flip && i[lg]) begin
      // Odd tile of the mirrored pair: reflect the offset.
      map_axis = s_m1 - m;
    end else begin
      map_axis = m;
    end
  endfunction

  state_t              state;
  logic                u_flip_r, v_flip_r, u_clamp_r, v_clamp_r;
  logic [2:0]          u_size_r, v_size_r;
  logic signed [31:0]  du_r, dv_r;
  logic signed [31:0]  u_acc, v_acc;
  logic [LEN_W-1:0]    remain;
  logic [9:0]          ui_r, vi_r;
  logic [PIX_W-1:0]    pix_r;
  logic                last_r, valid_r, done_r;

  logic                hs;
  logic [9:0]          u_first, v_first, u_next, v_next;

  logic                unused_inst;
  assign unused_inst = ^{uv.tsp_inst[31:19], uv.tsp_inst[14:6]};

  assign hs = valid_r & uv.uv_ready;

  // Pixel 0 is mapped straight from the setup inputs with the live
  // instruction word; later pixels use the latched copy.
  assign u_first = map_axis(uv.u_start[31:16], uv.tsp_inst[5:3],
                            uv.tsp_inst[18], uv.tsp_inst[16]);
  assign v_first = map_axis(uv.v_start[31:16], uv.tsp_inst[2:0],
                            uv.tsp_inst[17], uv.tsp_inst[15]);
  assign u_next  = map_axis(u_acc[31:16], u_size_r, u_flip_r, u_clamp_r);
  assign v_next  = map_axis(v_acc[31:16], v_size_r, v_flip_r, v_clamp_r);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      u_flip_r  <= 1'b0;
      v_flip_r  <= 1'b0;
      u_clamp_r <= 1'b0;
      v_clamp_r <= 1'b0;
      u_size_r  <= '0;
      v_size_r  <= '0;
      du_r      <= '0;
      dv_r      <= '0;
      u_acc     <= '0;
      v_acc     <= '0;
      remain    <= '0;
      ui_r      <= '0;
      vi_r      <= '0;
      pix_r     <= '0;
      last_r    <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (uv.start) begin
            if (uv.span_len != '0) begin
              u_flip_r  <= uv.tsp_inst[18];
              v_flip_r  <= uv.tsp_inst[17];
              u_clamp_r <= uv.tsp_inst[16];
              v_clamp_r <= uv.tsp_inst[15];
              u_size_r  <= uv.tsp_inst[5:3];
              v_size_r  <= uv.tsp_inst[2:0];
              du_r      <= $signed(uv.du_dx);
              dv_r      <= $signed(uv.dv_dx);
              ui_r      <= u_first;
              vi_r      <= v_first;
              pix_r     <= '0;
              last_r    <= (uv.span_len == LEN_W'(1));
              valid_r   <= 1'b1;
              u_acc     <= $signed(uv.u_start) + $signed(uv.du_dx);
              v_acc     <= $signed(uv.v_start) + $signed(uv.dv_dx);
              remain    <= uv.span_len - 1'b1;
              state     <= RUN;
            end else begin
              // Empty span: acknowledge with span_done only.
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            if (remain != '0) begin
              ui_r   <= u_next;
              vi_r   <= v_next;
              pix_r  <= pix_r + 1'b1;
              last_r <= (remain == LEN_W'(1));
              u_acc  <= u_acc + du_r;
              v_acc  <= v_acc + dv_r;
              remain <= remain - 1'b1;
            end else begin
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uv.busy      = (state == RUN);
  assign uv.uv_valid  = valid_r;
  assign uv.ui        = ui_r;
  assign uv.vi        = vi_r;
  assign uv.pix_x     = pix_r;
  assign uv.span_last = last_r;
  assign uv.span_done = done_r;
endmodule

// File: doc/tex_uv_stepper.md
# tex_uv_stepper

Per-span texture coordinate generator that sits directly upstream of `texture_address`. It steps affine 16.16 U/V accumulators across one span of up to 32 pixels and applies the TSP wrap modes (repeat, flip, clamp) per axis. It delivers integer texel coordinates `ui`/`vi` (10 bits each) one pixel per cycle over a valid/ready handshake.

## Interface
Parameters:
- `MAX_SPAN`, 32: maximum pixels per span; sets the `span_len` and `pix_x` widths.

Ports:
- `clock` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: span setup strobe; honoured only while `busy`=0.
- `tsp_inst` in 32: TSP instruction word. Fields used:
  - [18] u_flip, [17] v_flip, [16] u_clamp, [15] v_clamp
  - [5:3] u_size, [2:0] v_size (size = 8<<n)
- `u_start`, `v_start` in 32: signed 16.16 texel coordinate at the first pixel.
- `du_dx`, `dv_dx` in 32: signed 16.16 per-pixel increments.
- `span_len` in 6: pixel count, 0..32.
- `busy` out 1: span in progress.
- `uv_valid` out 1: `ui`/`vi`/`pix_x`/`span_last` are valid.
- `uv_ready` in 1: consumer accepts the current coordinate.
- `ui`, `vi` out 10: wrapped integer texel coordinates.
- `pix_x` out 5: pixel index within the span.
- `span_last` out 1: current coordinate is the final pixel of the span.
- `span_done` out 1: one-cycle pulse after the final handshake.

## Operation
- States: IDLE, RUN.
- IDLE + `start` + `span_len`!=0:
  - Latch `tsp_inst`, `du_dx`, `dv_dx`.
  - Load output regs with map(`u_start`), map(`v_start`); `pix_x`=0; `span_last`=(`span_len`==1); `uv_valid`=1.
  - `u_acc`=`u_start`+`du_dx`, `v_acc`=`v_start`+`dv_dx`; `remain`=`span_len`-1; go RUN.
- IDLE + `start` + `span_len`==0: no output; `span_done` pulses next cycle; stay IDLE.
- RUN, handshake (`uv_valid`&`uv_ready`):
  - If `remain`!=0: load map(`u_acc`/`v_acc`); `pix_x`++; `span_last`=(`remain`==1); acc += d*_dx; `remain`--.
  - If `remain`==0: `uv_valid`=0, pulse `span_done`, go IDLE.
- RUN without handshake: all outputs and accumulators hold.
- `start` during RUN is ignored; latched parameters do not change mid-span.
- `busy` = (state==RUN).
- map(acc), per axis, with i = acc[31:16] (signed 16), S = 8<<size, m = i & (S-1):
  - clamp=1 (takes priority over flip): i<0 → 0; i≥S → S-1; else i.
  - flip=1: i bit log2(S) set → S-1-m; else m.
  - otherwise (repeat): m.
  - Result is zero-extended to 10 bits.
- Accumulators are 32-bit two's complement and wrap silently on overflow.

## Timing
- Reset values: state IDLE; `busy`, `uv_valid`, `span_last`, `span_done` = 0; `ui`, `vi`, `pix_x` = 0; accumulators 0.
- Reset asserted mid-span: abort immediately, no `span_done`.
- Latency: `start` at edge N → `uv_valid`=1 with pixel 0 during cycle N+1.
- Throughput: 1 pixel/cycle while `uv_ready` is held high; an N-pixel span ends in N handshakes.
- `span_done` and `busy`=0 appear in the cycle after the last handshake. A new `start` in that cycle is accepted, giving a one-cycle bubble between spans.
- Output stability: while `uv_valid`=1 and `uv_ready`=0, all outputs are held stable. `uv_valid` never drops without a handshake.
- map() is combinational from the accumulators into the output registers; no extra pipeline stage.

## Test plan
- Repeat: u_size=0, `u_start`=0x00060000, `du_dx`=0x00010000, `span_len`=4, `uv_ready`=1 → `ui`=6,7,0,1; `pix_x`=0..3; `span_last` on the 4th; `span_done` pulse 1 cycle later.
- Flip, same setup with u_flip=1 → `ui`=6,7,7,6. Clamp, `u_start`=0xFFFE0000, u_clamp=1 → `ui`=0,0,0,1. Clamp with flip also set → same 0,0,0,1.
- V axis independence: v_size=7, `v_start`=0x03FF8000, `dv_dx`=0x00008000, repeat, `span_len`=3 → `vi`=1023,0,0. `ui` is unaffected by the V settings.
- Backpressure: `span_len`=32, `uv_ready` toggled pseudo-randomly → exactly 32 handshakes, `pix_x` 0..31 in order, outputs stable on every stalled cycle.
- Edge cases:
  - `span_len`=0 → no `uv_valid`, `span_done` 1 cycle after `start`.
  - `start` while busy → ignored, running span unchanged.
  - `reset_n` low at pixel 5 of 10 → all outputs 0 asynchronously, no `span_done`; a fresh span afterwards starts at `pix_x`=0.
